// File: rtl/cnt_pkg.sv
// Shared state encoding and width default for the counter job scheduler.
package cnt_pkg;

    localparam int CNT_DATABIT_DEF = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } cnt_state_t;

endpackage

// File: rtl/cnt_job_fifo.sv
// Job count FIFO for the counter scheduler.
// A push is dropped when the FIFO is full, even if a pop happens in the same cycle.
module cnt_job_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/cnt_job_sched.sv
// Queues job counts and launches them one at a time on a downstream counter.
// Optional watchdog on the wait state: define CNT_JOB_SCHED_TIMEOUT_EN.
module cnt_job_sched
    import cnt_pkg::*;
#(
    parameter int DATABIT = CNT_DATABIT_DEF,
    parameter int DEPTH   = 4
`ifdef CNT_JOB_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_job_valid,
    input  logic [DATABIT-1:0]       i_job_num,
    output logic                     o_job_ready,
    input  logic                     i_cnt_idle,
    input  logic                     i_cnt_done,
    output logic                     o_run,
    output logic [DATABIT-1:0]       o_num_cnt,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [7:0]               o_jobs_done
`ifdef CNT_JOB_SCHED_TIMEOUT_EN
    ,
    output logic                     o_timeout
`endif
);

    cnt_state_t         state;
    cnt_state_t         state_nxt;
    logic [DATABIT-1:0] head;
    logic [DATABIT-1:0] num_cnt_q;
    logic [7:0]         jobs_done_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               launch;
    logic               job_finish;

`ifdef CNT_JOB_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          timeout_q;
`endif

    cnt_job_fifo #(
        .WIDTH (DATABIT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (i_job_valid),
        .din     (i_job_num),
        .pop     (pop),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            num_cnt_q   <= '0;
            jobs_done_q <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                num_cnt_q <= head;
            end
            if (job_finish) begin
                jobs_done_q <= jobs_done_q + 8'd1;
            end
        end
    end

    // A zero-count head is retired straight away instead of being launched.
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        launch     = 1'b0;
        job_finish = 1'b0;
`ifdef CNT_JOB_SCHED_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty && i_cnt_idle) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                pop = 1'b1;
                if (head == '0) begin
                    job_finish = 1'b1;
                    state_nxt  = S_IDLE;
                end else begin
                    launch    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_cnt_done) begin
                    job_finish = 1'b1;
                    state_nxt  = S_IDLE;
                end
`ifdef CNT_JOB_SCHED_TIMEOUT_EN
                else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_IDLE;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef CNT_JOB_SCHED_TIMEOUT_EN
    // wait_cnt holds the number of wait cycles already elapsed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q || timeout_hit;
`endif

    assign o_job_ready = !fifo_full;
    assign o_run       = launch;
    assign o_num_cnt   = launch ? head : num_cnt_q;
    assign o_busy      = (state != S_IDLE);
    assign o_jobs_done = jobs_done_q;

endmodule

// File: doc/cnt_job_sched.md
CNT_JOB_SCHED -- requirements
Module: cnt_job_sched

Interface
REQ-001 Parameter DATABIT, default 7, SHALL set the width of a job count value.
REQ-002 Parameter DEPTH, default 4, SHALL set the job FIFO depth (power of two, 2..16).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_job_valid  input  1  SHALL flag a job offered this cycle.
REQ-006 i_job_num  input  DATABIT  SHALL carry the requested count for the offered job.
REQ-007 o_job_ready  output  1  SHALL indicate a job can be accepted this cycle.
REQ-008 i_cnt_idle  input  1  SHALL be the downstream counter's idle status.
REQ-009 i_cnt_done  input  1  SHALL be the downstream counter's done status.
REQ-010 o_run  output  1  SHALL be a one-cycle start pulse to the downstream counter.
REQ-011 o_num_cnt  output  DATABIT  SHALL hold the launched job's count, stable from the o_run cycle until the next launch.
REQ-012 o_busy  output  1  SHALL be high whenever the FSM is not in S_IDLE.
REQ-013 o_level  output  $clog2(DEPTH)+1  SHALL report the FIFO occupancy.
REQ-014 o_jobs_done  output  8  SHALL count completed jobs.

Function
REQ-015 A job SHALL be accepted in any cycle where i_job_valid and o_job_ready are both high; o_job_ready SHALL equal (o_level != DEPTH).
REQ-016 When the FIFO is full, an offered job SHALL be ignored even if a pop occurs in the same cycle.
REQ-017 A simultaneous push and pop SHALL leave o_level unchanged and preserve FIFO order.
REQ-018 The FSM SHALL have the states S_IDLE, S_LAUNCH and S_WAIT.
REQ-019 S_IDLE -> S_LAUNCH SHALL occur when the FIFO is non-empty and i_cnt_idle is high.
REQ-020 In S_LAUNCH, for exactly one cycle, the block SHALL assert o_run, load o_num_cnt from the FIFO head and pop the head; the next state SHALL be S_WAIT.
REQ-021 A head entry with i_job_num==0 SHALL be popped in S_LAUNCH without asserting o_run; o_jobs_done SHALL increment and the next state SHALL be S_IDLE.
REQ-022 S_WAIT -> S_IDLE SHALL occur on the first cycle with i_cnt_done high, incrementing o_jobs_done by 1.
REQ-023 o_jobs_done SHALL wrap from 255 to 0.
REQ-024 Latency from a push into an empty FIFO, with i_cnt_idle high, to o_run SHALL be 2 cycles.
REQ-025 i_cnt_done seen outside S_WAIT SHALL be ignored.

Reset
REQ-026 While reset_n is low, the following SHALL hold: state=S_IDLE, FIFO empty, o_level=0, o_job_ready=1, o_run=0, o_num_cnt=0, o_busy=0, o_jobs_done=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued jobs and any in-flight wait immediately.

Configuration
REQ-028 With macro CNT_JOB_SCHED_TIMEOUT_EN defined, the block SHALL add parameter TIMEOUT (default 1024) and a sticky output o_timeout.
REQ-029 Under that macro, S_WAIT lasting TIMEOUT cycles without i_cnt_done SHALL return the FSM to S_IDLE, set o_timeout and leave o_jobs_done unchanged; only reset clears o_timeout.
REQ-030 Without the macro, no o_timeout port or watchdog logic SHALL exist, and S_WAIT SHALL wait indefinitely.

Structure
REQ-031 The package cnt_pkg SHALL hold the FSM state enum and the DATABIT default.
REQ-032 The FIFO SHALL be the sub-module cnt_job_fifo (push/pop/full/empty/level); the FSM and counters SHALL live in the top level.

Verification
REQ-033 Reset, then push job 100 with i_cnt_idle=1 -> o_run pulse 2 cycles later with o_num_cnt=100; i_cnt_done after 100 cycles -> o_jobs_done=1, o_busy=0.
REQ-034 Push 5 jobs (10,20,30,40,50) with i_cnt_idle=0 -> first 4 accepted, o_level=4, o_job_ready=0, fifth dropped; launches then occur in order 10,20,30,40.
REQ-035 Push job 0, then job 7 -> no o_run for job 0, o_jobs_done=1; o_run with o_num_cnt=7 follows.
REQ-036 With FIFO level 2, push on the same cycle as a pop -> o_level stays 2 and launch order is preserved.
REQ-037 Assert reset_n=0 during S_WAIT with 3 jobs queued -> all outputs return to reset values; no o_run after release.
REQ-038 With CNT_JOB_SCHED_TIMEOUT_EN and TIMEOUT=16, withhold i_cnt_done -> o_timeout=1 at the 16th S_WAIT cycle, the FSM returns to S_IDLE and o_jobs_done is unchanged.
